// File: rtl/bin2bcd_if.sv
// Handshake and result bundle between a requester and bin2bcd_seq.
// The requester drives start/bin; the converter returns busy/done/bcd/ovf.
interface bin2bcd_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD, one bit per clock; done pulses BIN_W+1 cycles after start.
// Start is ignored while busy. Optional BCD_LZ_BLANK_EN replaces leading zero digits with 4'hF.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  bin2bcd_if.slave io
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] sh;
  logic [SW-1:0] adj;
  logic [SW-1:0] sh_next;
  logic          top_bit;
  logic [CW-1:0] cnt;
  logic          ovf_acc;
  logic [BW-1:0] bcd_q;
  logic          ovf_q;
  logic [BW-1:0] result;

`ifdef BCD_LZ_BLANK_EN
  // Digits above the most significant nonzero digit become blank; digit 0 always shows.
  function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] d);
    logic seen;
    blank_lz = d;
    seen     = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (d[4*i +: 4] != 4'd0) seen = 1'b1;
      if (!seen) blank_lz[4*i +: 4] = 4'hF;
    end
  endfunction
`endif

  // Per-digit add-3 correction, no carry between digits, ahead of the shift.
  always_comb begin
    adj = sh;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh[BIN_W + 4*i +: 4] >= 4'd5)
        adj[BIN_W + 4*i +: 4] = sh[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  assign sh_next = {adj[SW-2:0], 1'b0};
  assign top_bit = adj[SW-1];

`ifdef BCD_LZ_BLANK_EN
  assign result = blank_lz(sh_next[SW-1:BIN_W]);
`else
  assign result = sh_next[SW-1:BIN_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sh      <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.start) begin
            sh      <= {{BW{1'b0}}, io.bin};
            cnt     <= CW'(BIN_W);
            ovf_acc <= 1'b0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sh      <= sh_next;
          ovf_acc <= ovf_acc | top_bit;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_q <= result;
            ovf_q <= ovf_acc | top_bit;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign io.busy = (state != S_IDLE);
  assign io.done = (state == S_DONE);
  assign io.bcd  = bcd_q;
  assign io.ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: drivers push expected {bcd,ovf}, monitors pop on done.
module tb_bin2bcd_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bin2bcd_if #(.BIN_W(8), .DIGITS(3)) ifa ();
  bin2bcd_if #(.BIN_W(8), .DIGITS(2)) ifb ();
  bin2bcd_if #(.BIN_W(1), .DIGITS(1)) ifc ();

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (.clk(clk), .rst_n(rst_n), .io(ifa));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (.clk(clk), .rst_n(rst_n), .io(ifb));
  bin2bcd_seq #(.BIN_W(1), .DIGITS(1)) dut_c (.clk(clk), .rst_n(rst_n), .io(ifc));

`ifdef BCD_LZ_BLANK_EN
  localparam logic [11:0] E067 = 12'hF67, E255 = 12'h255, E000 = 12'hFF0, E056 = 12'hF56;
  localparam logic [11:0] E009 = 12'hFF9, E007 = 12'hFF7, E105 = 12'h105, EB00 = 12'h0F0;
`else
  localparam logic [11:0] E067 = 12'h067, E255 = 12'h255, E000 = 12'h000, E056 = 12'h056;
  localparam logic [11:0] E009 = 12'h009, E007 = 12'h007, E105 = 12'h105, EB00 = 12'h000;
`endif

  // Expected entries are {bcd[11:0], ovf}.
  logic [12:0] qa[$];
  logic [12:0] qb[$];
  logic [12:0] qc[$];
  logic [12:0] ea, eb, ec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifa.done === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_bcd", 32'(ifa.bcd), 32'(ea[12:1]));
        chk("a_ovf", 32'(ifa.ovf), 32'(ea[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifb.done === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_bcd", 32'(ifb.bcd), 32'(eb[12:1]));
        chk("b_ovf", 32'(ifb.ovf), 32'(eb[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifc.done === 1'b1) begin
      if (qc.size() == 0) chk("c_unexpected_done", 1, 0);
      else begin
        ec = qc.pop_front();
        chk("c_bcd", 32'(ifc.bcd), 32'(ec[12:1]));
        chk("c_ovf", 32'(ifc.ovf), 32'(ec[0]));
      end
    end
  end

  // Full timing check on the 3-digit unit; dup_at>0 re-asserts start at edge k+dup_at.
  task automatic run_a(input logic [7:0] v, input logic [11:0] e_bcd, input logic e_ovf,
                       input int dup_at);
    int busy_n, done_n, done_at;
    @(negedge clk);
    ifa.start = 1'b1;
    ifa.bin   = v;
    qa.push_back({e_bcd, e_ovf});
    @(posedge clk);
    #1;
    ifa.start = 1'b0;
    ifa.bin   = 8'hA5;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int j = 0; j < 14; j++) begin
      if (ifa.busy === 1'b1) busy_n++;
      if (ifa.done === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = j;
      end
      if (j == dup_at - 1) begin
        ifa.start = 1'b1;
        ifa.bin   = 8'd99;
      end else begin
        ifa.start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    chk("a_busy_cycles", busy_n, 9);
    chk("a_done_latency", done_at, 8);
    chk("a_done_count", done_n, 1);
  endtask

  // Narrow units: start, then wait (bounded) for busy to drop.
  task automatic run_bc(input int which, input logic [7:0] v, input logic [11:0] e_bcd,
                        input logic e_ovf, input int e_cycles);
    int n;
    @(negedge clk);
    if (which == 1) begin
      ifb.start = 1'b1; ifb.bin = v; qb.push_back({e_bcd, e_ovf});
    end else begin
      ifc.start = 1'b1; ifc.bin = v[0]; qc.push_back({e_bcd, e_ovf});
    end
    @(posedge clk);
    #1;
    ifb.start = 1'b0;
    ifc.start = 1'b0;
    n = 0;
    while (((which == 1) ? ifb.busy : ifc.busy) === 1'b1 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk((which == 1) ? "b_busy_cycles" : "c_busy_cycles", n, e_cycles);
  endtask

  initial begin
    ifa.start = 1'b0; ifa.bin = '0;
    ifb.start = 1'b0; ifb.bin = '0;
    ifc.start = 1'b0; ifc.bin = '0;

    #50;
    chk("rst_busy", 32'(ifa.busy), 0);
    chk("rst_done", 32'(ifa.done), 0);
    chk("rst_bcd", 32'(ifa.bcd), 0);
    chk("rst_ovf", 32'(ifa.ovf), 0);
    chk("rst_b_bcd", 32'(ifb.bcd), 0);
    #50;
    @(negedge clk);
    rst_n = 1'b1;

    run_a(8'd67,  E067, 1'b0, -1);
    run_a(8'd255, E255, 1'b0, -1);
    run_a(8'd0,   E000, 1'b0, -1);
    run_a(8'd56,  E056, 1'b0, 3);

    // Abort a conversion with reset at edge k+4; previous result must hold until then.
    @(negedge clk);
    ifa.start = 1'b1;
    ifa.bin   = 8'd123;
    @(posedge clk);
    #1;
    ifa.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("a_bcd_hold_during_conv", 32'(ifa.bcd), 32'(E056));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(ifa.busy), 0);
    chk("abort_done", 32'(ifa.done), 0);
    chk("abort_bcd", 32'(ifa.bcd), 0);
    chk("abort_ovf", 32'(ifa.ovf), 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    run_a(8'd9,   E009, 1'b0, -1);
    run_a(8'd7,   E007, 1'b0, -1);
    run_a(8'd105, E105, 1'b0, -1);

    run_bc(1, 8'd200, EB00,    1'b1, 9);
    run_bc(1, 8'd99,  12'h099, 1'b0, 9);
    run_bc(2, 8'd1,   12'h001, 1'b0, 2);
    run_bc(2, 8'd0,   12'h000, 1'b0, 2);

    repeat (4) @(posedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    chk("c_queue_drained", qc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
